// File: rtl/alu_exec.sv
// alu_exec: execute-stage ALU, 32-bit ops plus int8x4 NN ops; ALU_EXEC_SAT_EN selects saturating ADD/SUB/CONV2D.
// Ports: clk_i, rst_n_i, valid_i/ready_o + ALUCtrl_i/data1_i/data2_i in; valid_o/ready_i + result_o/zero_o out.
module alu_exec (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        valid_i,
  output logic        ready_o,
  input  logic [3:0]  ALUCtrl_i,
  input  logic [31:0] data1_i,
  input  logic [31:0] data2_i,
  output logic        valid_o,
  input  logic        ready_i,
  output logic [31:0] result_o,
  output logic        zero_o
);

  localparam logic [3:0] OP_SUB  = 4'b0010;
  localparam logic [3:0] OP_AND  = 4'b0011;
  localparam logic [3:0] OP_OR   = 4'b0100;
  localparam logic [3:0] OP_MUL  = 4'b0110;
  localparam logic [3:0] OP_RELU = 4'b0111;
  localparam logic [3:0] OP_MAX  = 4'b1000;
  localparam logic [3:0] OP_FC   = 4'b1001;
  localparam logic [3:0] OP_CONV = 4'b1010;
  localparam logic [3:0] OP_BN   = 4'b1011;

  typedef enum logic [1:0] {
    S_IDLE, S_MUL, S_DOT, S_DONE
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  op_q, op_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [31:0] prod_q, prod_d;
  logic [31:0] psum_q, psum_d;
  logic [31:0] acc_q, acc_d;
  logic [31:0] res_q, res_d;
  logic        zero_q, zero_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [1:0]  lane_q, lane_d;

  logic signed [15:0] lp;
  logic [31:0] pnx, psum_nx, bn_v;

  function automatic logic [31:0] add_sat(
    input logic [31:0] a,
    input logic [31:0] b,
    input logic        sub
  );
    logic [31:0] bb, s;
    bb = sub ? ~b : b;
    s  = a + bb + {31'd0, sub};
`ifdef ALU_EXEC_SAT_EN
    if (a[31] == bb[31] && s[31] != a[31])
      s = a[31] ? 32'h8000_0000 : 32'h7fff_ffff;
`endif
    return s;
  endfunction

  function automatic logic [31:0] alu1(
    input logic [3:0]  op,
    input logic [31:0] a,
    input logic [31:0] b
  );
    logic [31:0] r;
    r = add_sat(a, b, 1'b0);
    unique case (op)
      OP_SUB: r = add_sat(a, b, 1'b1);
      OP_AND: r = a & b;
      OP_OR:  r = a | b;
      OP_RELU:
        for (int k = 0; k < 4; k++)
          r[8*k +: 8] = a[8*k+7] ? 8'd0 : a[8*k +: 8];
      OP_MAX:
        for (int k = 0; k < 4; k++)
          r[8*k +: 8] =
            ($signed(a[8*k +: 8]) > $signed(b[8*k +: 8]))
            ? a[8*k +: 8] : b[8*k +: 8];
      default: ;
    endcase
    return r;
  endfunction

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    prod_d  = prod_q;
    psum_d  = psum_q;
    acc_d   = acc_q;
    res_d   = res_q;
    zero_d  = zero_q;
    cnt_d   = cnt_q;
    lane_d  = lane_q;

    lp      = $signed(a_q[7:0]) * $signed(b_q[7:0]);
    psum_nx = psum_q + {{16{lp[15]}}, lp};
    pnx     = prod_q + (b_q[0] ? a_q : 32'd0);
    bn_v    = $signed(pnx) >>> 8;

    unique case (state_q)
      S_IDLE: if (valid_i) begin
        op_d = ALUCtrl_i;
        a_d  = data1_i;
        b_d  = data2_i;
        unique case (ALUCtrl_i)
          OP_MUL, OP_BN: begin
            if (ALUCtrl_i == OP_BN) begin
              a_d = {{16{data1_i[15]}}, data1_i[15:0]};
              b_d = {{16{data2_i[15]}}, data2_i[15:0]};
            end
            prod_d  = '0;
            cnt_d   = '0;
            state_d = S_MUL;
          end
          OP_FC, OP_CONV: begin
            psum_d  = '0;
            lane_d  = '0;
            state_d = S_DOT;
          end
          default: begin
            res_d   = alu1(ALUCtrl_i, data1_i, data2_i);
            state_d = S_DONE;
          end
        endcase
      end
      // Shift-add: multiplicand moves left, multiplier right.
      S_MUL: begin
        prod_d = pnx;
        a_d    = a_q << 1;
        b_d    = b_q >> 1;
        cnt_d  = cnt_q + 5'd1;
        if (cnt_q == 5'd31) begin
          res_d   = (op_q == OP_BN) ? bn_v : pnx;
          state_d = S_DONE;
        end
      end
      // Operands shift down a lane per cycle; lane 0 is always used.
      S_DOT: begin
        psum_d = psum_nx;
        a_d    = a_q >> 8;
        b_d    = b_q >> 8;
        lane_d = lane_q + 2'd1;
        if (lane_q == 2'd3) begin
          acc_d   = (op_q == OP_FC) ? psum_nx
                  : add_sat(acc_q, psum_nx, 1'b0);
          res_d   = acc_d;
          state_d = S_DONE;
        end
      end
      S_DONE: if (ready_i) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (state_q != S_DONE && state_d == S_DONE)
      zero_d = (res_d == 32'd0);
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      prod_q  <= '0;
      psum_q  <= '0;
      acc_q   <= '0;
      res_q   <= '0;
      zero_q  <= 1'b0;
      cnt_q   <= '0;
      lane_q  <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      prod_q  <= prod_d;
      psum_q  <= psum_d;
      acc_q   <= acc_d;
      res_q   <= res_d;
      zero_q  <= zero_d;
      cnt_q   <= cnt_d;
      lane_q  <= lane_d;
    end
  end

  assign ready_o  = rst_n_i && (state_q == S_IDLE);
  assign valid_o  = (state_q == S_DONE);
  assign result_o = res_q;
  assign zero_o   = zero_q;

endmodule

// File: tb/tb_alu_exec.sv
// tb_alu_exec: vector table, hand sequences and random ops vs a reference model.
// Drives/samples 1 time unit after rising edges.
module tb_alu_exec;

  logic        clk = 1'b0;
  logic        rst_n_i;
  logic        valid_i, ready_o, valid_o, ready_i, zero_o;
  logic [3:0]  ALUCtrl_i;
  logic [31:0] data1_i, data2_i, result_o;

  int checks = 0;
  int errors = 0;
  logic [31:0] macc = 0;

  alu_exec dut (
    .clk_i    (clk),
    .rst_n_i  (rst_n_i),
    .valid_i  (valid_i),
    .ready_o  (ready_o),
    .ALUCtrl_i(ALUCtrl_i),
    .data1_i  (data1_i),
    .data2_i  (data2_i),
    .valid_o  (valid_o),
    .ready_i  (ready_i),
    .result_o (result_o),
    .zero_o   (zero_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] e;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, expv);
    end
  endtask

  function automatic logic [31:0] sadd(input logic [31:0] a,
                                       input logic [31:0] b,
                                       input bit sub);
    longint s;
    s = sub ? longint'($signed(a)) - longint'($signed(b))
            : longint'($signed(a)) + longint'($signed(b));
`ifdef ALU_EXEC_SAT_EN
    if (s > 64'sd2147483647) s = 64'sd2147483647;
    if (s < -64'sd2147483648) s = -64'sd2147483648;
`endif
    return 32'(s);
  endfunction

  function automatic logic [31:0] dot4(input logic [31:0] a,
                                       input logic [31:0] b);
    int  s;
    byte x, y;
    s = 0;
    for (int k = 0; k < 4; k++) begin
      x = a[8*k +: 8];
      y = b[8*k +: 8];
      s += int'(x) * int'(y);
    end
    return s;
  endfunction

  function automatic logic [31:0] model(input logic [3:0] op,
                                        input logic [31:0] a,
                                        input logic [31:0] b);
    logic [31:0] r;
    byte x, y;
    int  p;
    case (op)
      4'd2: r = sadd(a, b, 1'b1);
      4'd3: r = a & b;
      4'd4: r = a | b;
      4'd6: r = a * b;
      4'd7: for (int k = 0; k < 4; k++) begin
        x = a[8*k +: 8];
        r[8*k +: 8] = (x < 0) ? 8'd0 : x;
      end
      4'd8: for (int k = 0; k < 4; k++) begin
        x = a[8*k +: 8];
        y = b[8*k +: 8];
        r[8*k +: 8] = (x > y) ? x : y;
      end
      4'd9: begin macc = dot4(a, b); r = macc; end
      4'd10: begin macc = sadd(macc, dot4(a, b), 1'b0); r = macc; end
      4'd11: begin
        p = int'($signed(a[15:0])) * int'($signed(b[15:0]));
        r = p >>> 8;
      end
      default: r = sadd(a, b, 1'b0);
    endcase
    return r;
  endfunction

  function automatic int explat(input logic [3:0] op);
    if (op == 4'd6 || op == 4'd11) return 33;
    if (op == 4'd9 || op == 4'd10) return 5;
    return 1;
  endfunction

  task automatic do_op(input string nm, input logic [3:0] op,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] expv, input int hold);
    int lat, busy, w;
    w = 0;
    while (!ready_o && w < 10) begin
      @(posedge clk); #1; w++;
    end
    chk({nm, " ready"}, 32'(ready_o), 32'd1);
    valid_i = 1'b1; ALUCtrl_i = op; data1_i = a; data2_i = b;
    @(posedge clk); #1;
    valid_i = 1'b0;
    lat = 1; busy = 0;
    while (!valid_o && lat < 100) begin
      if (ready_o) busy++;
      data1_i = $urandom; data2_i = $urandom;
      ALUCtrl_i = 4'($urandom);
      @(posedge clk); #1; lat++;
    end
    chk({nm, " latency"}, 32'(lat), 32'(explat(op)));
    chk({nm, " busy"}, 32'(busy), 32'd0);
    chk({nm, " result"}, result_o, expv);
    chk({nm, " zero"}, 32'(zero_o), 32'(expv == 32'd0));
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk({nm, " hold valid"}, 32'(valid_o), 32'd1);
      chk({nm, " hold result"}, result_o, expv);
      chk({nm, " hold ready"}, 32'(ready_o), 32'd0);
    end
    ready_i = 1'b1;
    @(posedge clk); #1;
    ready_i = 1'b0;
    chk({nm, " drop valid"}, 32'(valid_o), 32'd0);
    chk({nm, " idle ready"}, 32'(ready_o), 32'd1);
  endtask

  vec_t tbl[10];

  initial begin
    logic [3:0]  op;
    logic [31:0] a, b, e;

    rst_n_i = 1'b0; valid_i = 1'b0; ready_i = 1'b0;
    ALUCtrl_i = '0; data1_i = '0; data2_i = '0;
    #1;
    chk("rst ready", 32'(ready_o), 32'd0);
    chk("rst valid", 32'(valid_o), 32'd0);
    chk("rst result", result_o, 32'd0);
    chk("rst zero", 32'(zero_o), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n_i = 1'b1;
    #1 chk("post rst ready", 32'(ready_o), 32'd1);

    tbl[0] = '{4'd1, 32'd5, 32'd7, 32'd12};
    tbl[1] = '{4'd2, 32'd7, 32'd7, 32'd0};
    tbl[2] = '{4'd7, 32'h80FF017F, 32'h0, 32'h0000017F};
    tbl[3] = '{4'd8, 32'h01FE7F80, 32'hFF028000, 32'h01027F00};
    tbl[4] = '{4'd3, 32'hF0F01234, 32'h0FF0FF00, 32'h00F01200};
    tbl[5] = '{4'd4, 32'hF0000001, 32'h000F0010, 32'hF00F0011};
    tbl[6] = '{4'd0, 32'd3, 32'd4, 32'd7};
    tbl[7] = '{4'd15, 32'hFFFFFFFF, 32'd1, 32'd0};
    tbl[8] = '{4'd2, 32'd3, 32'd5, 32'hFFFFFFFE};
`ifdef ALU_EXEC_SAT_EN
    tbl[9] = '{4'd1, 32'h7FFFFFFF, 32'd1, 32'h7FFFFFFF};
`else
    tbl[9] = '{4'd1, 32'h7FFFFFFF, 32'd1, 32'h80000000};
`endif
    for (int i = 0; i < 10; i++)
      do_op($sformatf("vec%0d", i), tbl[i].op, tbl[i].a,
            tbl[i].b, tbl[i].e, 0);

    do_op("mul", 4'd6, 32'h00010003, 32'h5, 32'h0005000F, 0);
    do_op("fc", 4'd9, 32'h01020304, 32'h01010101, 32'd10, 0);
    do_op("conv", 4'd10, 32'h01020304, 32'h01010101, 32'd20, 0);
    do_op("bn", 4'd11, 32'h100, 32'hFF00, 32'hFFFFFF00, 0);
    do_op("bp", 4'd1, 32'd100, 32'd23, 32'd123, 4);

    valid_i = 1'b1; ALUCtrl_i = 4'd6;
    data1_i = 32'h1234; data2_i = 32'h5678;
    @(posedge clk); #1;
    valid_i = 1'b0;
    repeat (9) @(posedge clk);
    #1 rst_n_i = 1'b0;
    #1;
    chk("abort valid", 32'(valid_o), 32'd0);
    chk("abort result", result_o, 32'd0);
    chk("abort ready", 32'(ready_o), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n_i = 1'b1;
    #1 chk("abort ready rel", 32'(ready_o), 32'd1);
    repeat (40) begin
      @(posedge clk); #1;
      if (valid_o) break;
    end
    chk("abort no valid", 32'(valid_o), 32'd0);
    do_op("conv acc clr", 4'd10, 32'h01020304, 32'h01010101,
          32'd10, 0);
    macc = 32'd10;

    for (int i = 0; i < 150; i++) begin
      op = 4'($urandom_range(0, 15));
      a = $urandom;
      b = $urandom;
      if (i % 8 == 0) begin op = 4'd2; b = a; end
      if (i % 8 == 1) begin a = 32'h7FFFFFF0 + 32'($urandom_range(0, 15)); end
      e = model(op, a, b);
      do_op($sformatf("rnd%0d op%0d", i, op), op, a, b, e,
            $urandom_range(0, 2));
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
